// File: rtl/iic_arbiter.sv
// iic_arbiter: round-robin sequencer sharing one iic_w write engine among NUM_REQ clients.
// Define IIC_ARB_TIMEOUT_EN to add the start/busy watchdog abort path.
//
// state   | meaning
// S_IDLE  | wait for a request while the engine is idle
// S_ARB   | winner and its fields latched, grant visible
// S_START | iic_start held high until the engine reports busy
// S_RUN   | transfer in progress, wait for busy to fall
// S_DONE  | done pulse to the winner, lock updated
module iic_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned BUSY_TIMEOUT  = 1 << 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_addr,
  input  logic [NUM_REQ*128-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]   req_len,
  input  logic [NUM_REQ-1:0]     req_hold,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             iic_address,
  output logic [127:0]           iic_data,
  output logic [7:0]             iic_length,
  output logic                   iic_do_not_end,
  output logic                   iic_start,
  input  logic                   iic_busy
);

  localparam int unsigned        IW        = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [IW-1:0]      LAST_IDX  = IW'(NUM_REQ - 1);
  localparam logic [31:0]        START_LIM = 32'(START_TIMEOUT - 1);
  localparam logic [31:0]        BUSY_LIM  = 32'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic [7:0]           addr_q, addr_d;
  logic [127:0]         data_q, data_d;
  logic [7:0]           len_q, len_d;
  logic                 dne_q, dne_d;
  logic                 start_q, start_d;
  logic [IW-1:0]        win_q, win_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic                 lock_q, lock_d;

  logic [IW-1:0]        cand;
  logic [IW-1:0]        rr_idx;
  logic [IW-1:0]        win_idx;
  logic                 lock_hit;
  logic                 timeout;

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    rr_idx = rr_q;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req[cand]) rr_idx = cand;
    end
  end

  assign lock_hit = lock_q && req[win_q];
  assign win_idx  = lock_hit ? win_q : rr_idx;

`ifdef IIC_ARB_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;

  // Counter restarts on every state change, so it measures time spent in START or RUN.
  always_comb begin
    wdog_d = (state_d != state_q) ? 32'd0 : wdog_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wdog_q <= 32'd0;
    else        wdog_q <= wdog_d;
  end

  assign timeout = ((state_q == S_START) && (wdog_q == START_LIM)) ||
                   ((state_q == S_RUN)   && (wdog_q == BUSY_LIM));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{START_LIM, BUSY_LIM};
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    err_d   = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    len_d   = len_q;
    dne_d   = dne_q;
    win_d   = win_q;
    rr_d    = rr_q;
    lock_d  = lock_q;

    case (state_q)
      S_IDLE: begin
        // Winner is latched on entry to ARB so grant shows one cycle after the request.
        if ((|req) && !iic_busy) begin
          state_d = S_ARB;
          win_d   = win_idx;
          grant_d = ONE_HOT0 << win_idx;
          addr_d  = req_addr[{win_idx, 3'b000} +: 8];
          data_d  = req_data[{win_idx, 7'b0000000} +: 128];
          len_d   = req_len[{win_idx, 3'b000} +: 8];
          dne_d   = req_hold[win_idx];
          rr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
          lock_d  = lock_hit;
        end
      end
      S_ARB: begin
        state_d = S_START;
      end
      S_START: begin
        if (iic_busy) begin
          state_d = S_RUN;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = grant_q;
          grant_d = '0;
          lock_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (!iic_busy) begin
          state_d = S_DONE;
          done_d  = grant_q;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = grant_q;
          grant_d = '0;
          lock_d  = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        lock_d  = dne_q;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    start_d = (state_d == S_START);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      dne_q   <= 1'b0;
      start_q <= 1'b0;
      win_q   <= '0;
      rr_q    <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      len_q   <= len_d;
      dne_q   <= dne_d;
      start_q <= start_d;
      win_q   <= win_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign err            = err_q;
  assign iic_address    = addr_q;
  assign iic_data       = data_q;
  assign iic_length     = len_q;
  assign iic_do_not_end = dne_q;
  assign iic_start      = start_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter: vector table for arbitration order and lock,
// hand-written sequences for single transfer, reset mid-run and start timeout.
module tb_iic_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*8-1:0]   req_addr;
  logic [N*128-1:0] req_data;
  logic [N*8-1:0]   req_len;
  logic [N-1:0]     req_hold;
  logic [N-1:0]     grant, done, err;
  logic [7:0]       iic_address;
  logic [127:0]     iic_data;
  logic [7:0]       iic_length;
  logic             iic_do_not_end, iic_start;
  logic             iic_busy;

  bit               model_en;
  int               busy_len;
  int               checks = 0;
  int               failures = 0;

  logic [7:0]       cfg_addr [N];
  logic [127:0]     cfg_data [N];
  logic [7:0]       cfg_len  [N];

  typedef struct {
    bit           rst_before;
    logic [N-1:0] req;
    logic [N-1:0] hold;
    logic [N-1:0] exp_grant;
  } vec_t;

  vec_t vecs [15];

  iic_arbiter #(
    .NUM_REQ      (N),
    .START_TIMEOUT(16),
    .BUSY_TIMEOUT (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_len       (req_len),
    .req_hold      (req_hold),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .iic_address   (iic_address),
    .iic_data      (iic_data),
    .iic_length    (iic_length),
    .iic_do_not_end(iic_do_not_end),
    .iic_start     (iic_start),
    .iic_busy      (iic_busy)
  );

  always #5 clk = ~clk;

  // Engine model: busy rises half a cycle after start is seen, stays high busy_len cycles.
  initial begin
    iic_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && iic_start && !iic_busy) begin
        iic_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        iic_busy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_hold = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input int lim, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < lim) begin
      tick();
      cyc++;
      if (grant != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int lim, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < lim) begin
      tick();
      cyc++;
      if (done != '0) ok = 1'b1;
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    oh2idx = 0;
    for (int i = 0; i < N; i++) if (v[i]) oh2idx = i;
  endfunction

  initial begin
    int           cyc, st_cnt, dn_cnt, er_cnt, bad_g, bad_d, miss, w;
    bit           ok, addr_moved;
    logic [N-1:0] dn_val, er_val;

    cfg_addr[0] = 8'h4E; cfg_data[0] = 128'hF0;                       cfg_len[0] = 8'd1;
    cfg_addr[1] = 8'h51; cfg_data[1] = {4{32'hA1A1_0001}};            cfg_len[1] = 8'd2;
    cfg_addr[2] = 8'h62; cfg_data[2] = {8{16'hB2C3}};                 cfg_len[2] = 8'd16;
    cfg_addr[3] = 8'h73; cfg_data[3] = 128'h0123_4567_89AB_CDEF_FEDC; cfg_len[3] = 8'd0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*8 +: 8]     = cfg_addr[i];
      req_data[i*128 +: 128] = cfg_data[i];
      req_len[i*8 +: 8]      = cfg_len[i];
    end

    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001};
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0010};
    vecs[2]  = '{1'b0, 4'b1111, 4'b0000, 4'b0100};
    vecs[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b1000};
    vecs[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001};
    vecs[5]  = '{1'b1, 4'b0011, 4'b0001, 4'b0001};
    vecs[6]  = '{1'b0, 4'b0011, 4'b0001, 4'b0001};
    vecs[7]  = '{1'b0, 4'b0010, 4'b0000, 4'b0010};
    vecs[8]  = '{1'b0, 4'b1001, 4'b0000, 4'b1000};
    vecs[9]  = '{1'b0, 4'b0101, 4'b0000, 4'b0001};
    vecs[10] = '{1'b0, 4'b0110, 4'b0000, 4'b0010};
    vecs[11] = '{1'b0, 4'b1100, 4'b0000, 4'b0100};
    vecs[12] = '{1'b0, 4'b1000, 4'b1000, 4'b1000};
    vecs[13] = '{1'b0, 4'b1010, 4'b0000, 4'b1000};
    vecs[14] = '{1'b0, 4'b0010, 4'b0000, 4'b0010};

    model_en = 1'b0;
    busy_len = 1;
    do_reset();
    chk("rst_grant",   128'(grant), 128'd0);
    chk("rst_done",    128'(done), 128'd0);
    chk("rst_err",     128'(err), 128'd0);
    chk("rst_start",   128'(iic_start), 128'd0);
    chk("rst_dne",     128'(iic_do_not_end), 128'd0);
    chk("rst_address", 128'(iic_address), 128'd0);
    chk("rst_data",    iic_data, 128'd0);
    chk("rst_length",  128'(iic_length), 128'd0);

    // Single transfer: latency, field capture, input changes after grant ignored.
    model_en = 1'b1;
    busy_len = 20;
    req      = 4'b0001;
    tick();
    chk("t1_grant_p1", 128'(grant), 128'h1);
    chk("t1_start_p1", 128'(iic_start), 128'd0);
    tick();
    chk("t1_start_p2", 128'(iic_start), 128'd1);
    chk("t1_address",  128'(iic_address), 128'h4E);
    chk("t1_data",     iic_data, 128'hF0);
    chk("t1_length",   128'(iic_length), 128'd1);
    req_addr[7:0] = 8'hFF;
    req           = '0;
    st_cnt     = 1;
    dn_cnt     = 0;
    dn_val     = '0;
    addr_moved = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (iic_start) st_cnt++;
      if (done != '0) begin
        dn_cnt++;
        dn_val = done;
      end
      if (iic_address != 8'h4E) addr_moved = 1'b1;
    end
    chk("t1_start_cycles", 128'(st_cnt), 128'd1);
    chk("t1_done_count",   128'(dn_cnt), 128'd1);
    chk("t1_done_value",   128'(dn_val), 128'h1);
    chk("t1_addr_stable",  128'(addr_moved), 128'd0);
    chk("t1_grant_clear",  128'(grant), 128'd0);
    req_addr[7:0] = cfg_addr[0];

    // Arbitration order, lock and release from the vector table.
    busy_len = 3;
    for (int v = 0; v < 15; v++) begin
      if (vecs[v].rst_before) do_reset();
      req      = vecs[v].req;
      req_hold = vecs[v].hold;
      tick();
      wait_grant(40, cyc, ok);
      chk($sformatf("v%0d_grant_seen", v), 128'(ok), 128'd1);
      if (!vecs[v].rst_before)
        chk($sformatf("v%0d_done_to_grant", v), 128'(cyc + 1), 128'd2);
      w = oh2idx(vecs[v].exp_grant);
      chk($sformatf("v%0d_grant", v),   128'(grant), 128'(vecs[v].exp_grant));
      chk($sformatf("v%0d_address", v), 128'(iic_address), 128'(cfg_addr[w]));
      chk($sformatf("v%0d_data", v),    iic_data, cfg_data[w]);
      chk($sformatf("v%0d_length", v),  128'(iic_length), 128'(cfg_len[w]));
      chk($sformatf("v%0d_dne", v),     128'(iic_do_not_end), 128'(|(vecs[v].hold & vecs[v].exp_grant)));
      wait_done(60, cyc, ok);
      chk($sformatf("v%0d_done", v), 128'(done), 128'(vecs[v].exp_grant));
    end

    // Reset in the middle of RUN: transfer abandoned, new grant waits for busy to drop.
    do_reset();
    busy_len = 30;
    req      = 4'b0001;
    wait_grant(10, cyc, ok);
    chk("t4_grant_seen", 128'(ok), 128'd1);
    repeat (4) tick();
    chk("t4_in_run_busy", 128'(iic_busy), 128'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t4_grant",   128'(grant), 128'd0);
    chk("t4_done",    128'(done), 128'd0);
    chk("t4_start",   128'(iic_start), 128'd0);
    chk("t4_address", 128'(iic_address), 128'd0);
    chk("t4_data",    iic_data, 128'd0);
    chk("t4_length",  128'(iic_length), 128'd0);
    chk("t4_dne",     128'(iic_do_not_end), 128'd0);
    bad_g = 0;
    bad_d = 0;
    cyc   = 0;
    while (iic_busy && cyc < 60) begin
      tick();
      cyc++;
      if (iic_busy && grant != '0) bad_g++;
      if (done != '0) bad_d++;
    end
    chk("t4_busy_dropped",     128'(iic_busy), 128'd0);
    chk("t4_no_grant_in_busy", 128'(bad_g), 128'd0);
    chk("t4_no_done",          128'(bad_d), 128'd0);
    wait_grant(10, cyc, ok);
    chk("t4_regrant_latency", 128'(cyc), 128'd1);
    chk("t4_regrant",         128'(grant), 128'h1);
    wait_done(80, cyc, ok);
    chk("t4_done_after", 128'(done), 128'h1);
    req = '0;

    // Engine never raises busy.
    do_reset();
    model_en = 1'b0;
    req      = 4'b0001;
`ifdef IIC_ARB_TIMEOUT_EN
    st_cnt = 0;
    er_cnt = 0;
    dn_cnt = 0;
    er_val = '0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (iic_start) st_cnt++;
      if (done != '0) dn_cnt++;
      if (err != '0) begin
        er_cnt++;
        er_val = err;
        req    = '0;
      end
    end
    chk("t5_start_cycles", 128'(st_cnt), 128'd16);
    chk("t5_err_count",    128'(er_cnt), 128'd1);
    chk("t5_err_value",    128'(er_val), 128'h1);
    chk("t5_no_done",      128'(dn_cnt), 128'd0);
    chk("t5_grant_clear",  128'(grant), 128'd0);
`else
    tick();
    tick();
    miss   = 0;
    er_cnt = 0;
    dn_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (!iic_start) miss++;
      if (err != '0) er_cnt++;
      if (done != '0) dn_cnt++;
    end
    chk("t5_start_held", 128'(miss), 128'd0);
    chk("t5_err_zero",   128'(er_cnt), 128'd0);
    chk("t5_no_done",    128'(dn_cnt), 128'd0);
    chk("t5_grant_held", 128'(grant), 128'h1);
`endif
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
